lab3_mem_mem_req_arbiter: RTL and testbench

//  Sits directly downstream of two blocking caches (icache = port 0, dcache = port 1).

---
 rtl/lab3_mem_mem_req_arbiter_pkg.sv | 45 ++++
 rtl/lab3_mem_mem_req_arbiter_src_id_queue.sv | 88 ++++++++
 rtl/lab3_mem_mem_req_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_lab3_mem_mem_req_arbiter.sv | 543 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_mem_mem_req_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// lab3_mem_mem_req_arbiter_pkg
//
// Purpose : Shared definitions for the two-cache memory request arbiter.
//           It defines the source-ID type that tags every in-flight request.
//           It defines the field widths of the 16-byte memory request and
//           response messages, and the total widths derived from them.
//
// Contents:
//   src_id_t           1-bit requester identifier
//   SRC_ICACHE         port 0 (instruction cache)
//   SRC_DCACHE         port 1 (data cache)
//   c_memreq_nbits     mem_req_16B width  (type/opaque/addr/len/data)
//   c_memresp_nbits    mem_resp_16B width (type/opaque/test/len/data)
//   other_src()        returns the opposite requester
// ----------------------------------------------------------------------------
package lab3_mem_mem_req_arbiter_pkg;

    typedef logic src_id_t;

    localparam src_id_t SRC_ICACHE = 1'b0;
    localparam src_id_t SRC_DCACHE = 1'b1;

    // Field widths of the 16-byte memory messages.
    localparam int c_mem_type_nbits   = 3;
    localparam int c_mem_opaque_nbits = 8;
    localparam int c_mem_addr_nbits   = 32;
    localparam int c_mem_test_nbits   = 2;
    localparam int c_mem_len_nbits    = 4;
    localparam int c_mem_data_nbits   = 128;

    localparam int c_memreq_nbits  = c_mem_type_nbits + c_mem_opaque_nbits
                                   + c_mem_addr_nbits + c_mem_len_nbits
                                   + c_mem_data_nbits;

    localparam int c_memresp_nbits = c_mem_type_nbits + c_mem_opaque_nbits
                                   + c_mem_test_nbits + c_mem_len_nbits
                                   + c_mem_data_nbits;

    // Round-robin helper: the port that gets priority after 'id' is served.
    function automatic src_id_t other_src(input src_id_t id);
        return (id == SRC_ICACHE) ? SRC_DCACHE : SRC_ICACHE;
    endfunction

endpackage

// File: rtl/lab3_mem_mem_req_arbiter_src_id_queue.sv
// ----------------------------------------------------------------------------
// lab3_mem_mem_req_arbiter_src_id_queue
//
// Purpose : FIFO of requester IDs, one entry per memory request in flight.
//           The head entry names the cache that owns the next in-order
//           memory response.
//
// Parameters:
//   p_depth    number of entries (power of two, >= 2)
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset (empties the queue)
//   i_enq_en   in   push i_enq_id (ignored when full)
//   i_enq_id   in   requester ID to push
//   i_deq_en   in   pop the head entry (ignored when empty)
//   o_full     out  p_depth entries held
//   o_empty    out  no entries held
//   o_head     out  oldest entry; meaningless while o_empty
// ----------------------------------------------------------------------------
module lab3_mem_mem_req_arbiter_src_id_queue
    import lab3_mem_mem_req_arbiter_pkg::*;
#(
    parameter int p_depth = 4
)(
    input  logic    clk,
    input  logic    reset,
    input  logic    i_enq_en,
    input  src_id_t i_enq_id,
    input  logic    i_deq_en,
    output logic    o_full,
    output logic    o_empty,
    output src_id_t o_head
);

    localparam int c_ptr_nbits = $clog2(p_depth);
    localparam logic [c_ptr_nbits-1:0] c_ptr_one  = c_ptr_nbits'(1);
    localparam logic [c_ptr_nbits:0]   c_cnt_one  = (c_ptr_nbits + 1)'(1);
    localparam logic [c_ptr_nbits:0]   c_cnt_full = (c_ptr_nbits + 1)'(p_depth);

    src_id_t                r_mem [p_depth];
    logic [c_ptr_nbits-1:0] r_wr_ptr;
    logic [c_ptr_nbits-1:0] r_rd_ptr;
    logic [c_ptr_nbits:0]   r_count;

    logic w_do_enq;
    logic w_do_deq;

    assign o_full   = (r_count == c_cnt_full);
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rd_ptr];

    assign w_do_enq = i_enq_en & ~o_full;
    assign w_do_deq = i_deq_en & ~o_empty;

    // NOTE: storage is deliberately left out of reset; the count guards every
    // read, so stale entries are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_enq) begin
            r_mem[r_wr_ptr] <= i_enq_id;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_deq) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lab3_mem_mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// lab3_mem_mem_req_arbiter
//
// Purpose : Merges the memory request streams of two blocking caches
//           (port 0 = icache, port 1 = dcache) onto one memory port with
//           round-robin arbitration. The request path is purely combinational.
//           A source-ID queue remembers the requester of every in-flight
//           request. Each in-order memory response is steered back to the
//           cache that issued the matching request.
//
// Build option:
//   LAB3_MEM_ARB_STATS_EN  adds three 32-bit wrap-around statistics counters
//                          and their output ports. The arbitration behaviour
//                          is the same with or without this option.
//
// Parameters:
//   p_req_nbits    memory request message width
//   p_resp_nbits   memory response message width
//   p_num_inflt    maximum requests in flight (power of two, >= 2)
//
// Ports:
//   clk, reset                            clock; synchronous active-high reset
//   i_req0_val/o_req0_rdy/i_req0_msg      icache request handshake
//   i_req1_val/o_req1_rdy/i_req1_msg      dcache request handshake
//   o_memreq_val/i_memreq_rdy/o_memreq_msg     merged request to memory
//   i_memresp_val/o_memresp_rdy/i_memresp_msg  response from memory
//   o_resp0_val/i_resp0_rdy/o_resp0_msg   icache response handshake
//   o_resp1_val/i_resp1_rdy/o_resp1_msg   dcache response handshake
//   o_stat_grant0/1, o_stat_conflict      counters (stats build only)
// ----------------------------------------------------------------------------
module lab3_mem_mem_req_arbiter
    import lab3_mem_mem_req_arbiter_pkg::*;
#(
    parameter int p_req_nbits  = c_memreq_nbits,
    parameter int p_resp_nbits = c_memresp_nbits,
    parameter int p_num_inflt  = 4
)(
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    i_req0_val,
    output logic                    o_req0_rdy,
    input  logic [p_req_nbits-1:0]  i_req0_msg,

    input  logic                    i_req1_val,
    output logic                    o_req1_rdy,
    input  logic [p_req_nbits-1:0]  i_req1_msg,

    output logic                    o_memreq_val,
    input  logic                    i_memreq_rdy,
    output logic [p_req_nbits-1:0]  o_memreq_msg,

    input  logic                    i_memresp_val,
    output logic                    o_memresp_rdy,
    input  logic [p_resp_nbits-1:0] i_memresp_msg,

    output logic                    o_resp0_val,
    input  logic                    i_resp0_rdy,
    output logic [p_resp_nbits-1:0] o_resp0_msg,

    output logic                    o_resp1_val,
    input  logic                    i_resp1_rdy,
    output logic [p_resp_nbits-1:0] o_resp1_msg
`ifdef LAB3_MEM_ARB_STATS_EN
    ,
    output logic [31:0]             o_stat_grant0,
    output logic [31:0]             o_stat_grant1,
    output logic [31:0]             o_stat_conflict
`endif
);

    src_id_t r_prio;

    src_id_t w_grant;
    src_id_t w_head;
    logic    w_q_full;
    logic    w_q_empty;
    logic    w_can_issue;
    logic    w_any_req;
    logic    w_issue_ok;
    logic    w_resp_ok;
    logic    w_memreq_go;
    logic    w_memresp_go;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------

    // The port named by r_prio wins a tie; a lone requester always wins.
    // NOTE: the default assignment first makes every path through the block
    // drive w_grant, so no latch is inferred.
    always_comb begin
        w_grant = r_prio;
        if (i_req0_val && !i_req1_val) begin
            w_grant = SRC_ICACHE;
        end else if (i_req1_val && !i_req0_val) begin
            w_grant = SRC_DCACHE;
        end
    end

    // A full queue blocks issue even when a pop happens in the same cycle;
    // the freed slot becomes usable only on the following cycle.
    assign w_can_issue  = ~w_q_full;
    assign w_any_req    = i_req0_val | i_req1_val;

    // Outputs are gated by reset so every val/rdy is low while reset is held.
    assign o_memreq_val = ~reset & w_any_req & w_can_issue;
    assign o_memreq_msg = (w_grant == SRC_DCACHE) ? i_req1_msg : i_req0_msg;

    assign w_issue_ok   = ~reset & w_can_issue & i_memreq_rdy;
    assign o_req0_rdy   = w_issue_ok & (w_grant == SRC_ICACHE);
    assign o_req1_rdy   = w_issue_ok & (w_grant == SRC_DCACHE);

    assign w_memreq_go  = o_memreq_val & i_memreq_rdy;

    // Priority moves only when a request is consumed. The grant may change
    // while memory stalls, which is harmless because nothing is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= SRC_ICACHE;
        end else if (w_memreq_go) begin
            r_prio <= other_src(w_grant);
        end
    end

    // ------------------------------------------------------------------
    // Source-ID queue
    // ------------------------------------------------------------------
    lab3_mem_mem_req_arbiter_src_id_queue #(
        .p_depth  (p_num_inflt)
    ) u_src_q (
        .clk      (clk),
        .reset    (reset),
        .i_enq_en (w_memreq_go),
        .i_enq_id (w_grant),
        .i_deq_en (w_memresp_go),
        .o_full   (w_q_full),
        .o_empty  (w_q_empty),
        .o_head   (w_head)
    );

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------

    // The queue head names the owner of the next response. The other port
    // never sees val. Both message outputs simply mirror memory.
    assign w_resp_ok     = ~reset & ~w_q_empty;

    assign o_resp0_val   = w_resp_ok & i_memresp_val & (w_head == SRC_ICACHE);
    assign o_resp1_val   = w_resp_ok & i_memresp_val & (w_head == SRC_DCACHE);
    assign o_resp0_msg   = i_memresp_msg;
    assign o_resp1_msg   = i_memresp_msg;

    assign o_memresp_rdy = w_resp_ok &
                           ((w_head == SRC_DCACHE) ? i_resp1_rdy : i_resp0_rdy);

    assign w_memresp_go  = i_memresp_val & o_memresp_rdy;

    // A response with nothing in flight is a memory-side protocol error.
    a_resp_needs_inflight: assert property (
        @(posedge clk) disable iff (reset) !(i_memresp_val && w_q_empty)
    );

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef LAB3_MEM_ARB_STATS_EN
    logic [31:0] r_stat_grant0;
    logic [31:0] r_stat_grant1;
    logic [31:0] r_stat_conflict;
    logic        w_conflict;

    // When both caches are valid, at most one is consumed, so the other
    // always stalls in that cycle.
    assign w_conflict = i_req0_val & i_req1_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_grant0   <= '0;
            r_stat_grant1   <= '0;
            r_stat_conflict <= '0;
        end else begin
            if (w_memreq_go && (w_grant == SRC_ICACHE)) begin
                r_stat_grant0 <= r_stat_grant0 + 32'd1;
            end
            if (w_memreq_go && (w_grant == SRC_DCACHE)) begin
                r_stat_grant1 <= r_stat_grant1 + 32'd1;
            end
            if (w_conflict) begin
                r_stat_conflict <= r_stat_conflict + 32'd1;
            end
        end
    end

    assign o_stat_grant0   = r_stat_grant0;
    assign o_stat_grant1   = r_stat_grant1;
    assign o_stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_lab3_mem_mem_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lab3_mem_mem_req_arbiter
//
// Directed checks of the two-port memory request arbiter, with one short
// randomised traffic run using two blocking-cache models and an in-order
// memory model. Inputs change 1 ns after the rising edge. Outputs are
// sampled 1 ns later, well away from the next edge.
// The handshake vector w_hs is {memreq_val, req0_rdy, req1_rdy, memresp_rdy,
// resp0_val, resp1_val}.
// ----------------------------------------------------------------------------
module tb_lab3_mem_mem_req_arbiter;

    logic         clk;
    logic         reset;
    logic         req0_val, req1_val, req0_rdy, req1_rdy;
    logic [174:0] req0_msg, req1_msg;
    logic         memreq_val, memreq_rdy;
    logic [174:0] memreq_msg;
    logic         memresp_val, memresp_rdy;
    logic [144:0] memresp_msg;
    logic         resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [144:0] resp0_msg, resp1_msg;
`ifdef LAB3_MEM_ARB_STATS_EN
    logic [31:0]  stat_grant0, stat_grant1, stat_conflict;
`endif

    logic [5:0]   w_hs;
    int           n_tests;
    int           n_fail;

    assign w_hs = {memreq_val, req0_rdy, req1_rdy, memresp_rdy, resp0_val, resp1_val};

    lab3_mem_mem_req_arbiter #(
        .p_req_nbits   (175),
        .p_resp_nbits  (145),
        .p_num_inflt   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req0_val    (req0_val),
        .o_req0_rdy    (req0_rdy),
        .i_req0_msg    (req0_msg),
        .i_req1_val    (req1_val),
        .o_req1_rdy    (req1_rdy),
        .i_req1_msg    (req1_msg),
        .o_memreq_val  (memreq_val),
        .i_memreq_rdy  (memreq_rdy),
        .o_memreq_msg  (memreq_msg),
        .i_memresp_val (memresp_val),
        .o_memresp_rdy (memresp_rdy),
        .i_memresp_msg (memresp_msg),
        .o_resp0_val   (resp0_val),
        .i_resp0_rdy   (resp0_rdy),
        .o_resp0_msg   (resp0_msg),
        .o_resp1_val   (resp1_val),
        .i_resp1_rdy   (resp1_rdy),
        .o_resp1_msg   (resp1_msg)
`ifdef LAB3_MEM_ARB_STATS_EN
        ,
        .o_stat_grant0   (stat_grant0),
        .o_stat_grant1   (stat_grant1),
        .o_stat_conflict (stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [174:0] mk_req(input logic [7:0] op, input logic [31:0] addr,
                                            input logic [127:0] data);
        return {3'd0, op, addr, 4'd0, data};
    endfunction

    function automatic logic [144:0] mk_resp(input logic [7:0] op, input logic [127:0] data);
        return {3'd0, op, 2'd0, 4'd0, data};
    endfunction

    function automatic logic [127:0] tag_data(input int c, input int t);
        return {64'(c), 64'(t)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        req0_val    = 1'b0;
        req1_val    = 1'b0;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        memresp_msg = '0;
        resp0_rdy   = 1'b1;
        resp1_rdy   = 1'b1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_hs(input string name, input logic [5:0] exp);
        n_tests++;
        if (w_hs !== exp) begin
            n_fail++;
            $display("FAIL %s: handshake got %b want %b", name, w_hs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset       = 1'b1;
        req0_val    = 1'b1;
        req1_val    = 1'b1;
        req0_msg    = '0;
        req1_msg    = '0;
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        memresp_msg = '0;
        resp0_rdy   = 1'b1;
        resp1_rdy   = 1'b1;
        tick();
        chk_hs("reset_hold_a", 6'b000000);
        tick();
        chk_hs("reset_hold_b", 6'b000000);
`ifdef LAB3_MEM_ARB_STATS_EN
        n_tests++;
        if ({stat_grant0, stat_grant1, stat_conflict} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0",
                     stat_grant0, stat_grant1, stat_conflict);
        end
`endif
        tick();
        reset = 1'b0;
        idle();
        settle();
        chk_hs("reset_release", 6'b000000);
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_port();
        logic [174:0] exp_req;
        logic [144:0] exp_resp;
        do_reset();
        exp_req  = mk_req(8'h11, 32'h0000_1000, 128'd0);
        exp_resp = mk_resp(8'h11, 128'hA5);
        tick();
        req0_val   = 1'b1;
        req0_msg   = mk_req(8'h11, 32'h0000_1000, 128'd0);
        memreq_rdy = 1'b1;
        settle();
        chk_hs("single_req", 6'b110000);
        n_tests++;
        if (memreq_msg !== exp_req) begin
            n_fail++;
            $display("FAIL single_req_msg: got %h want %h", memreq_msg, exp_req);
        end
        tick();
        req0_val    = 1'b0;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(8'h11, 128'hA5);
        settle();
        chk_hs("single_resp", 6'b000110);
        n_tests++;
        if (resp0_msg !== exp_resp) begin
            n_fail++;
            $display("FAIL single_resp_msg: got %h want %h", resp0_msg, exp_resp);
        end
        tick();
        memresp_val = 1'b0;
        settle();
        chk_hs("single_drained", 6'b000000);
    endtask

    // ------------------------------------------------------------------
    task automatic test_contention();
        logic [3:0]   exp_grants;
        logic [174:0] a0, a1, exp_req;
        logic [144:0] exp_resp;
        logic         g;
        exp_grants = 4'b1010;           // bit i = port granted on cycle i
        a0 = mk_req(8'h20, 32'h0000_2000, 128'd0);
        a1 = mk_req(8'h21, 32'h0000_3000, 128'd0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            req0_val   = 1'b1;
            req1_val   = 1'b1;
            req0_msg   = mk_req(8'h20, 32'h0000_2000, 128'd0);
            req1_msg   = mk_req(8'h21, 32'h0000_3000, 128'd0);
            memreq_rdy = 1'b1;
            settle();
            g = exp_grants[i];
            chk_hs($sformatf("contend_grant%0d", i), {1'b1, ~g, g, (i > 0), 2'b00});
            exp_req = g ? a1 : a0;
            n_tests++;
            if (memreq_msg !== exp_req) begin
                n_fail++;
                $display("FAIL contend_msg%0d: got %h want %h", i, memreq_msg, exp_req);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            req0_val    = 1'b0;
            req1_val    = 1'b0;
            memreq_rdy  = 1'b0;
            memresp_val = 1'b1;
            memresp_msg = mk_resp(8'(i), 128'(i + 100));
            settle();
            g = exp_grants[i];
            exp_resp = mk_resp(8'(i), 128'(i + 100));
            chk_hs($sformatf("contend_resp%0d", i), {3'b000, 1'b1, ~g, g});
            n_tests++;
            if ((g ? resp1_msg : resp0_msg) !== exp_resp) begin
                n_fail++;
                $display("FAIL contend_resp_msg%0d: got %h want %h", i,
                         g ? resp1_msg : resp0_msg, exp_resp);
            end
        end
        tick();
        memresp_val = 1'b0;
        settle();
        chk_hs("contend_drained", 6'b000000);
    endtask

    // ------------------------------------------------------------------
    task automatic test_full_queue();
        logic [174:0] exp_req;
        logic         g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            req0_val   = 1'b1;
            req0_msg   = mk_req(8'(8'h40 + i), 32'h0000_4000 + 32'(16 * i), 128'd0);
            memreq_rdy = 1'b1;
            settle();
            chk_hs($sformatf("full_fill%0d", i), {3'b110, (i > 0), 2'b00});
        end
        tick();
        req1_val = 1'b1;
        req1_msg = mk_req(8'h50, 32'h0000_5000, 128'd0);
        settle();
        chk_hs("full_blocked", 6'b000100);
        tick();
        memresp_val = 1'b1;
        memresp_msg = mk_resp(8'h40, 128'd1);
        settle();
        chk_hs("full_pop_same_cycle", 6'b000110);
        tick();
        memresp_val = 1'b0;
        settle();
        exp_req = mk_req(8'h50, 32'h0000_5000, 128'd0);
        chk_hs("full_resume", 6'b101100);
        n_tests++;
        if (memreq_msg !== exp_req) begin
            n_fail++;
            $display("FAIL full_resume_msg: got %h want %h", memreq_msg, exp_req);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            req0_val    = 1'b0;
            req1_val    = 1'b0;
            memreq_rdy  = 1'b0;
            memresp_val = 1'b1;
            settle();
            g = (i == 3);
            chk_hs($sformatf("full_drain%0d", i), {3'b000, 1'b1, ~g, g});
        end
        tick();
        memresp_val = 1'b0;
        settle();
        chk_hs("full_drained", 6'b000000);
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        logic [144:0] ra, rb;
        ra = mk_resp(8'h61, 128'hBEEF);
        rb = mk_resp(8'h60, 128'hCAFE);
        do_reset();
        tick();
        req1_val   = 1'b1;
        req1_msg   = mk_req(8'h61, 32'h0000_6100, 128'd0);
        memreq_rdy = 1'b1;
        settle();
        chk_hs("bp_issue1", 6'b101000);
        tick();
        req1_val = 1'b0;
        req0_val = 1'b1;
        req0_msg = mk_req(8'h60, 32'h0000_6000, 128'd0);
        settle();
        chk_hs("bp_issue0", 6'b110100);
        tick();
        req0_val    = 1'b0;
        memreq_rdy  = 1'b0;
        resp1_rdy   = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = mk_resp(8'h61, 128'hBEEF);
        settle();
        chk_hs("bp_stall_a", 6'b000001);
        tick();
        settle();
        chk_hs("bp_stall_b", 6'b000001);
        tick();
        resp1_rdy = 1'b1;
        settle();
        chk_hs("bp_release", 6'b000101);
        n_tests++;
        if (resp1_msg !== ra) begin
            n_fail++;
            $display("FAIL bp_release_msg: got %h want %h", resp1_msg, ra);
        end
        tick();
        memresp_msg = mk_resp(8'h60, 128'hCAFE);
        settle();
        chk_hs("bp_second", 6'b000110);
        n_tests++;
        if (resp0_msg !== rb) begin
            n_fail++;
            $display("FAIL bp_second_msg: got %h want %h", resp0_msg, rb);
        end
        tick();
        memresp_val = 1'b0;
        settle();
        chk_hs("bp_drained", 6'b000000);
    endtask

    // ------------------------------------------------------------------
    // Continuous contention while memory returns one response per cycle:
    // the queue pushes and pops together and its occupancy stays at one.
    task automatic test_push_pop_stream();
        logic g, gp;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            req0_val    = 1'b1;
            req1_val    = 1'b1;
            req0_msg    = mk_req(8'h70, 32'h0000_7000, 128'd0);
            req1_msg    = mk_req(8'h71, 32'h0000_7100, 128'd0);
            memreq_rdy  = 1'b1;
            memresp_val = (i > 0);
            memresp_msg = mk_resp(8'(i), 128'(i));
            settle();
            g  = 1'(i % 2);
            gp = 1'((i + 1) % 2);
            chk_hs($sformatf("stream%0d", i),
                   {1'b1, ~g, g, (i > 0), (i > 0) & ~gp, (i > 0) & gp});
        end
        tick();
        req0_val    = 1'b0;
        req1_val    = 1'b0;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b1;
        settle();
        chk_hs("stream_last", 6'b000101);
        tick();
        memresp_val = 1'b0;
        settle();
        chk_hs("stream_drained", 6'b000000);
`ifdef LAB3_MEM_ARB_STATS_EN
        n_tests++;
        if ({stat_grant0, stat_grant1, stat_conflict} !== {32'd5, 32'd5, 32'd10}) begin
            n_fail++;
            $display("FAIL stats: got %0d/%0d/%0d want 5/5/10",
                     stat_grant0, stat_grant1, stat_conflict);
        end
`endif
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midflight();
        logic [174:0] m0, m1;
        logic         g;
        m0 = mk_req(8'h80, 32'h0000_8000, 128'd0);
        m1 = mk_req(8'h81, 32'h0000_8100, 128'd0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            g          = (i == 1);
            req0_val   = ~g;
            req1_val   = g;
            req0_msg   = mk_req(8'h80, 32'h0000_8000, 128'd0);
            req1_msg   = mk_req(8'h81, 32'h0000_8100, 128'd0);
            memreq_rdy = 1'b1;
            settle();
            chk_hs($sformatf("mid_issue%0d", i), {1'b1, ~g, g, (i > 0), 2'b00});
        end
        tick();
        reset       = 1'b1;
        req0_val    = 1'b1;
        req1_val    = 1'b1;
        memresp_val = 1'b1;
        settle();
        chk_hs("mid_in_reset", 6'b000000);
        tick();
        reset       = 1'b0;
        memresp_val = 1'b0;
        memreq_rdy  = 1'b0;
        settle();
        chk_hs("mid_after_reset", 6'b100000);
        n_tests++;
        if (memreq_msg !== m0) begin
            n_fail++;
            $display("FAIL mid_prio: got %h want %h", memreq_msg, m0);
        end
        tick();
        req0_val   = 1'b0;
        memreq_rdy = 1'b1;
        settle();
        chk_hs("mid_req1_only", 6'b101000);
        n_tests++;
        if (memreq_msg !== m1) begin
            n_fail++;
            $display("FAIL mid_req1_msg: got %h want %h", memreq_msg, m1);
        end
        tick();
        req1_val    = 1'b0;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b1;
        settle();
        chk_hs("mid_resp1", 6'b000101);
        tick();
        memresp_val = 1'b0;
        settle();
        chk_hs("mid_drained", 6'b000000);
    endtask

    // ------------------------------------------------------------------
    // Two blocking caches with random request, sink and memory delays.
    // Each response must come back to its issuer, carrying that issuer's tag.
    task automatic test_random();
        logic [174:0] mq[$];
        logic [174:0] exp_req;
        logic [174:0] head;
        logic         pend [2];
        logic         busy [2];
        int           tag  [2];
        int           n_issued;
        int           n_done;
        logic         finished;
        do_reset();
        pend     = '{1'b0, 1'b0};
        busy     = '{1'b0, 1'b0};
        tag      = '{0, 0};
        n_issued = 0;
        n_done   = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            tick();
            for (int c = 0; c < 2; c++) begin
                if (cyc < 2000 && !pend[c] && !busy[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1'b1;
                    tag[c]  = tag[c] + 1;
                end
            end
            req0_val   = pend[0];
            req1_val   = pend[1];
            req0_msg   = mk_req(8'h00, 32'h0000_9000, tag_data(0, tag[0]));
            req1_msg   = mk_req(8'h01, 32'h0000_9100, tag_data(1, tag[1]));
            memreq_rdy = ($urandom_range(0, 3) != 0);
            resp0_rdy  = ($urandom_range(0, 2) != 0);
            resp1_rdy  = ($urandom_range(0, 2) != 0);
            if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
                head        = mq[0];
                memresp_val = 1'b1;
                memresp_msg = mk_resp(head[171:164], head[127:0]);
            end else begin
                memresp_val = 1'b0;
                memresp_msg = '0;
            end
            settle();
            if (memreq_val && memreq_rdy) mq.push_back(memreq_msg);
            if (memresp_val && memresp_rdy) void'(mq.pop_front());
            if (resp0_val && resp0_rdy) begin
                n_tests++;
                if (!busy[0] || resp0_msg[127:0] !== tag_data(0, tag[0])) begin
                    n_fail++;
                    $display("FAIL rand_resp0: got %h want %h busy %b", resp0_msg[127:0],
                             tag_data(0, tag[0]), busy[0]);
                end
                busy[0] = 1'b0;
                n_done++;
            end
            if (resp1_val && resp1_rdy) begin
                n_tests++;
                if (!busy[1] || resp1_msg[127:0] !== tag_data(1, tag[1])) begin
                    n_fail++;
                    $display("FAIL rand_resp1: got %h want %h busy %b", resp1_msg[127:0],
                             tag_data(1, tag[1]), busy[1]);
                end
                busy[1] = 1'b0;
                n_done++;
            end
            for (int c = 0; c < 2; c++) begin
                if (pend[c] && (c == 0 ? req0_rdy : req1_rdy)) begin
                    exp_req = mk_req(8'(c), 32'h0000_9000 + 32'(c * 256), tag_data(c, tag[c]));
                    n_tests++;
                    if (memreq_msg !== exp_req) begin
                        n_fail++;
                        $display("FAIL rand_req%0d: got %h want %h", c, memreq_msg, exp_req);
                    end
                    pend[c] = 1'b0;
                    busy[c] = 1'b1;
                    n_issued++;
                end
            end
            if (cyc >= 2000 && !pend[0] && !pend[1] && !busy[0] && !busy[1]) finished = 1'b1;
        end
        n_tests++;
        if (!finished || n_done != n_issued || n_issued == 0) begin
            n_fail++;
            $display("FAIL rand_complete: delivered %0d issued %0d drained %b",
                     n_done, n_issued, finished);
        end
        tick();
        idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_port();
        test_contention();
        test_full_queue();
        test_backpressure();
        test_push_pop_stream();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
